// File: rtl/telemetry_frame_sender_if.sv
// Sample/serializer/deserializer/status bundle for the telemetry frame sender.
// The block under test takes the slave view; the feeding environment takes master.
interface telemetry_frame_sender_if;
  logic        pkt_valid;
  logic        pkt_ready;
  logic [31:0] pos_x;
  logic [31:0] pos_y;
  logic [31:0] pos_z;
  logic [31:0] vel_x;
  logic [31:0] vel_y;
  logic [31:0] vel_z;
  logic [31:0] tx_data;
  logic        tx_send;
  logic        tx_ready;
  logic [31:0] rx_data;
  logic        rx_avail;
  logic [8:0]  cmd_out;
  logic        cmd_valid;
  logic        range_err;
  logic        timeout;
  logic        busy;

  modport master (
    output pkt_valid, pos_x, pos_y, pos_z, vel_x, vel_y, vel_z, tx_ready, rx_data, rx_avail,
    input  pkt_ready, tx_data, tx_send, cmd_out, cmd_valid, range_err, timeout, busy
  );

  modport slave (
    input  pkt_valid, pos_x, pos_y, pos_z, vel_x, vel_y, vel_z, tx_ready, rx_data, rx_avail,
    output pkt_ready, tx_data, tx_send, cmd_out, cmd_valid, range_err, timeout, busy
  );
endinterface

// File: rtl/telemetry_frame_sender.sv
// Frames one telemetry sample as START_CODE + six words over a valid/ready serializer,
// then waits for a range-checked thrust command or a response timeout.
module telemetry_frame_sender #(
  parameter logic [31:0] START_CODE   = 32'hAAAA_AAAA,
  parameter int unsigned GAP_CYCLES   = 4,
  parameter int unsigned RESP_TIMEOUT = 100000,
  parameter int unsigned TO_W         = 17
) (
  input  logic                      clk,
  input  logic                      rst,
  telemetry_frame_sender_if.slave   bus
);

  localparam int unsigned     GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(RESP_TIMEOUT - 1);
  localparam logic [2:0]       LAST_IDX = 3'd6;

  typedef enum logic [1:0] {IDLE, SEND, GAP, WAIT_RESP} state_t;

  state_t           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic [31:0]      smp_q [6];
  logic [31:0]      smp_d [6];
  logic [31:0]      tx_data_q, tx_data_d;
  logic [8:0]       cmd_q, cmd_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic             range_err_q, range_err_d;
  logic             timeout_q, timeout_d;
  logic             rx_avail_q;
  logic             rsp_evt, rsp_ok;
  logic [31:0]      next_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      gap_q       <= '0;
      to_q        <= '0;
      for (int unsigned i = 0; i < 6; i++) smp_q[i] <= '0;
      tx_data_q   <= '0;
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
      range_err_q <= 1'b0;
      timeout_q   <= 1'b0;
      rx_avail_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      gap_q       <= gap_d;
      to_q        <= to_d;
      smp_q       <= smp_d;
      tx_data_q   <= tx_data_d;
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
      range_err_q <= range_err_d;
      timeout_q   <= timeout_d;
      rx_avail_q  <= bus.rx_avail;
    end
  end

  // Response is a rising edge of the level-style avail; accepted range is signed 0..256.
  assign rsp_evt = bus.rx_avail & ~rx_avail_q;
  assign rsp_ok  = ~bus.rx_data[31] && (bus.rx_data <= 32'd256);

  always_comb begin
    case (idx_q)
      3'd1:    next_word = smp_q[0];
      3'd2:    next_word = smp_q[1];
      3'd3:    next_word = smp_q[2];
      3'd4:    next_word = smp_q[3];
      3'd5:    next_word = smp_q[4];
      3'd6:    next_word = smp_q[5];
      default: next_word = START_CODE;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    gap_d       = gap_q;
    to_d        = to_q;
    smp_d       = smp_q;
    tx_data_d   = tx_data_q;
    cmd_d       = cmd_q;
    cmd_valid_d = 1'b0;
    range_err_d = 1'b0;
    timeout_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.pkt_valid) begin
          smp_d[0]  = bus.pos_x;
          smp_d[1]  = bus.pos_y;
          smp_d[2]  = bus.pos_z;
          smp_d[3]  = bus.vel_x;
          smp_d[4]  = bus.vel_y;
          smp_d[5]  = bus.vel_z;
          idx_d     = '0;
          tx_data_d = START_CODE;
          state_d   = SEND;
        end
      end
      SEND: begin
        if (bus.tx_ready) begin
          idx_d = idx_q + 3'd1;
          if (idx_q == LAST_IDX) begin
            to_d    = '0;
            state_d = WAIT_RESP;
          end else begin
            gap_d   = '0;
            state_d = GAP;
          end
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          tx_data_d = next_word;
          state_d   = SEND;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      WAIT_RESP: begin
        // A response on the terminal-count edge takes priority over the timeout.
        if (rsp_evt) begin
          if (rsp_ok) begin
            cmd_d       = bus.rx_data[8:0];
            cmd_valid_d = 1'b1;
          end else begin
            range_err_d = 1'b1;
          end
          state_d = IDLE;
        end else if (to_q == TO_LAST) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.pkt_ready = (state_q == IDLE);
    bus.busy      = (state_q != IDLE);
    bus.tx_send   = (state_q == SEND);
    bus.tx_data   = tx_data_q;
    bus.cmd_out   = cmd_q;
    bus.cmd_valid = cmd_valid_q;
    bus.range_err = range_err_q;
    bus.timeout   = timeout_q;
  end

endmodule

// File: tb/tb_telemetry_frame_sender.sv
// Bench for telemetry_frame_sender: vector table, hand sequences for stall/reset,
// and randomized frames checked against a word-list / response-rule model.
module tb_telemetry_frame_sender;

  localparam int          GAP = 4;
  localparam int          TMO = 50;
  localparam logic [31:0] SC  = 32'hAAAA_AAAA;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  telemetry_frame_sender_if bus();

  telemetry_frame_sender #(
    .START_CODE  (SC),
    .GAP_CYCLES  (GAP),
    .RESP_TIMEOUT(TMO),
    .TO_W        (17)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [5:0][31:0] smp;
    logic [31:0]      resp;
    int               resp_at;
    int               hold;
    logic             exp_valid;
    logic             exp_err;
    logic             exp_to;
    logic [8:0]       exp_cmd;
  } vec_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [8:0]  ref_cmd;
  int          stall_cycles;
  int          acc_at   [7];
  logic [31:0] acc_word [7];
  vec_t        tbl [8];
  vec_t        rv;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0][31:0] mk(input logic [31:0] px, py, pz, vx, vy, vz);
    return {vz, vy, vx, pz, py, px};
  endfunction

  function automatic bit in_range(input logic [31:0] v);
    int s;
    s = $signed(v);
    return (s >= 0) && (s <= 256);
  endfunction

  function automatic logic [31:0] exp_word(input logic [5:0][31:0] smp, input int i);
    return (i == 0) ? SC : smp[i-1];
  endfunction

  // mode 0: ready always high, 1: random ready, 2: ready low 20 cycles from word 3
  task automatic run_frame(input logic [5:0][31:0] smp, input int mode, input bit stale);
    int cyc, cnt, stall_left, bad_busy, bad_hold, stray;
    bit prev_send, prev_acc;
    logic [31:0] prev_data;
    cyc = 0;
    @(negedge clk);
    while (!bus.pkt_ready && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    check("idle_before_frame", {31'd0, bus.pkt_ready}, 32'd1);
    @(posedge clk); #1;
    bus.pkt_valid = 1'b1;
    bus.pos_x = smp[0]; bus.pos_y = smp[1]; bus.pos_z = smp[2];
    bus.vel_x = smp[3]; bus.vel_y = smp[4]; bus.vel_z = smp[5];
    bus.tx_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge clk); #1;
    bus.pkt_valid = 1'b0;
    bus.pos_x = $urandom; bus.pos_y = $urandom; bus.pos_z = $urandom;
    bus.vel_x = $urandom; bus.vel_y = $urandom; bus.vel_z = $urandom;
    cnt = 0; cyc = 0; stall_left = 20; stall_cycles = 0;
    bad_busy = 0; bad_hold = 0; stray = 0;
    prev_send = 0; prev_acc = 0; prev_data = '0;
    while (cnt < 7 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (!bus.busy || bus.pkt_ready) bad_busy++;
      if (bus.cmd_valid || bus.range_err || bus.timeout) stray++;
      if (prev_send && !prev_acc && (!bus.tx_send || bus.tx_data !== prev_data)) bad_hold++;
      if (bus.tx_send && !bus.tx_ready && bus.tx_data == 32'd300) stall_cycles++;
      prev_send = bus.tx_send;
      prev_data = bus.tx_data;
      prev_acc  = bus.tx_send && bus.tx_ready;
      if (prev_acc) begin
        acc_word[cnt] = bus.tx_data;
        acc_at[cnt]   = cyc;
        cnt++;
      end
      if (cnt < 7) begin
        @(posedge clk); #1;
        case (mode)
          0: bus.tx_ready = 1'b1;
          1: bus.tx_ready = ($urandom_range(0, 3) != 0);
          default: begin
            if (cnt == 3 && stall_left > 0) begin
              bus.tx_ready = 1'b0;
              stall_left--;
            end else begin
              bus.tx_ready = 1'b1;
            end
          end
        endcase
        bus.rx_avail  = (stale && cnt < 6) ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.pkt_valid = stale ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.rx_data   = $urandom;
      end
    end
    check("frame_len", cnt, 32'd7);
    for (int i = 0; i < 7; i++)
      check($sformatf("word%0d", i), acc_word[i], exp_word(smp, i));
    if (mode == 0) begin
      check("first_accept_cycle", acc_at[0], 32'd1);
      for (int i = 1; i < 7; i++)
        check($sformatf("spacing%0d", i), acc_at[i] - acc_at[i-1], GAP + 1);
    end
    check("busy_during_frame", bad_busy, 32'd0);
    check("tx_hold_stable", bad_hold, 32'd0);
    check("no_pulse_during_frame", stray, 32'd0);
  endtask

  task automatic respond(input vec_t v);
    int n_v, n_e, n_t, p_at, exp_at, bad_busy;
    n_v = 0; n_e = 0; n_t = 0; p_at = 0; bad_busy = 0;
    exp_at = (v.resp_at > 0) ? v.resp_at + 1 : TMO + 1;
    for (int j = 1; j <= 60; j++) begin
      @(posedge clk); #1;
      bus.pkt_valid = 1'b0;
      bus.rx_avail  = (v.resp_at > 0) &&
                      ((j >= v.resp_at && j < v.resp_at + v.hold) || (j >= 56 && j < 58));
      bus.rx_data   = bus.rx_avail ? v.resp : $urandom;
      @(negedge clk);
      if (bus.cmd_valid) n_v++;
      if (bus.range_err) n_e++;
      if (bus.timeout)   n_t++;
      if ((bus.cmd_valid || bus.range_err || bus.timeout) && p_at == 0) p_at = j;
      if (bus.busy !== (j < exp_at)) bad_busy++;
    end
    bus.rx_avail = 1'b0;
    check("cmd_valid_pulses", n_v, {31'd0, v.exp_valid});
    check("range_err_pulses", n_e, {31'd0, v.exp_err});
    check("timeout_pulses", n_t, {31'd0, v.exp_to});
    check("pulse_cycle", p_at, exp_at);
    check("cmd_out", {23'd0, bus.cmd_out}, {23'd0, v.exp_cmd});
    check("busy_in_wait", bad_busy, 32'd0);
    check("idle_after_resp", {31'd0, bus.pkt_ready}, 32'd1);
  endtask

  task automatic do_vec(input vec_t v, input int mode, input bit stale);
    run_frame(v.smp, mode, stale);
    respond(v);
  endtask

  initial begin
    logic [5:0][31:0] basic;
    logic [5:0][31:0] alt;
    int               found;
    basic = mk(32'd100, 32'hFFFF_FF38, 32'd300, 32'hFFFF_FFFB, 32'd6, 32'd7);
    alt   = mk(32'h8000_0000, 32'h7FFF_FFFF, 32'd0, 32'hFFFF_FFFF, 32'd1, 32'h1234_5678);
    tbl[0] = '{smp: basic, resp: 32'd180,       resp_at: 3,  hold: 4, exp_valid: 1, exp_err: 0, exp_to: 0, exp_cmd: 9'd180};
    tbl[1] = '{smp: alt,   resp: 32'd257,       resp_at: 5,  hold: 2, exp_valid: 0, exp_err: 1, exp_to: 0, exp_cmd: 9'd180};
    tbl[2] = '{smp: basic, resp: 32'd256,       resp_at: 1,  hold: 1, exp_valid: 1, exp_err: 0, exp_to: 0, exp_cmd: 9'd256};
    tbl[3] = '{smp: alt,   resp: 32'hFFFF_FFFF, resp_at: 10, hold: 3, exp_valid: 0, exp_err: 1, exp_to: 0, exp_cmd: 9'd256};
    tbl[4] = '{smp: basic, resp: 32'd0,         resp_at: 20, hold: 5, exp_valid: 1, exp_err: 0, exp_to: 0, exp_cmd: 9'd0};
    tbl[5] = '{smp: alt,   resp: 32'd99,        resp_at: 0,  hold: 0, exp_valid: 0, exp_err: 0, exp_to: 1, exp_cmd: 9'd0};
    tbl[6] = '{smp: basic, resp: 32'd42,        resp_at: 50, hold: 2, exp_valid: 1, exp_err: 0, exp_to: 0, exp_cmd: 9'd42};
    tbl[7] = '{smp: alt,   resp: 32'h8000_0000, resp_at: 2,  hold: 4, exp_valid: 0, exp_err: 1, exp_to: 0, exp_cmd: 9'd42};

    rst = 1'b1;
    bus.pkt_valid = 0; bus.tx_ready = 0; bus.rx_avail = 0; bus.rx_data = '0;
    bus.pos_x = '0; bus.pos_y = '0; bus.pos_z = '0;
    bus.vel_x = '0; bus.vel_y = '0; bus.vel_z = '0;
    #1;
    check("rst_pkt_ready", {31'd0, bus.pkt_ready}, 32'd1);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_tx_send", {31'd0, bus.tx_send}, 32'd0);
    check("rst_tx_data", bus.tx_data, 32'd0);
    check("rst_cmd_out", {23'd0, bus.cmd_out}, 32'd0);
    check("rst_pulses", {29'd0, bus.cmd_valid, bus.range_err, bus.timeout}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) do_vec(tbl[i], 0, 1'b0);
    ref_cmd = tbl[7].exp_cmd;

    rv = '{smp: basic, resp: 32'd100, resp_at: 4, hold: 2, exp_valid: 1, exp_err: 0, exp_to: 0, exp_cmd: 9'd100};
    do_vec(rv, 2, 1'b0);
    check("stall_cycles_word3", stall_cycles, 32'd16);

    // Reset while vel_x (word 4) is being offered.
    @(posedge clk); #1;
    bus.pkt_valid = 1'b1;
    bus.pos_x = basic[0]; bus.pos_y = basic[1]; bus.pos_z = basic[2];
    bus.vel_x = basic[3]; bus.vel_y = basic[4]; bus.vel_z = basic[5];
    bus.tx_ready = 1'b1;
    @(posedge clk); #1;
    bus.pkt_valid = 1'b0;
    found = 0;
    for (int c = 0; c < 100 && found == 0; c++) begin
      @(negedge clk);
      if (bus.tx_send && bus.tx_data == basic[3]) found = 1;
    end
    check("reached_word4", bus.tx_data, basic[3]);
    #2 rst = 1'b1;
    #1;
    check("midrst_tx_send", {31'd0, bus.tx_send}, 32'd0);
    check("midrst_tx_data", bus.tx_data, 32'd0);
    check("midrst_busy", {31'd0, bus.busy}, 32'd0);
    check("midrst_pkt_ready", {31'd0, bus.pkt_ready}, 32'd1);
    check("midrst_cmd_out", {23'd0, bus.cmd_out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    rv = '{smp: basic, resp: 32'd180, resp_at: 3, hold: 4, exp_valid: 1, exp_err: 0, exp_to: 0, exp_cmd: 9'd180};
    do_vec(rv, 0, 1'b0);
    ref_cmd = 9'd180;

    for (int k = 0; k < 10; k++) begin
      int cat;
      rv.smp  = mk($urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
      cat     = $urandom_range(0, 4);
      case (cat)
        0:       rv.resp = $urandom_range(0, 256);
        1:       rv.resp = 32'd257 + $urandom_range(0, 5000);
        2:       rv.resp = -(32'd1 + $urandom_range(0, 1000));
        3:       rv.resp = $urandom;
        default: rv.resp = $urandom_range(0, 256);
      endcase
      rv.resp_at = (cat == 4) ? 0 : $urandom_range(1, TMO);
      rv.hold    = $urandom_range(1, 5);
      rv.exp_valid = 0; rv.exp_err = 0; rv.exp_to = 0;
      if (rv.resp_at == 0)             rv.exp_to = 1;
      else if (in_range(rv.resp)) begin
        rv.exp_valid = 1;
        ref_cmd = 9'($signed(rv.resp));
      end else                         rv.exp_err = 1;
      rv.exp_cmd = ref_cmd;
      do_vec(rv, 1, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/telemetry_frame_sender.md
Name: telemetry_frame_sender

Overview:
Ground-side counterpart of the flight controller link. It takes one telemetry sample (3 position and 3 velocity words) and frames it as START_CODE followed by six 32-bit words. The frame goes out through the word serializer (int_sender-style valid/ready). The block then waits for the controller's 32-bit thrust command from the word deserializer (int_receiver-style level "available"), range-checks it, and reports it, or flags a timeout.

Parameters:
START_CODE, 32'hAAAA_AAAA, frame-start word sent first.
GAP_CYCLES, 4, tx_send low-time between words; must be >= 1.
RESP_TIMEOUT, 100000, cycles allowed in WAIT_RESP before timeout.
TO_W, 17, width of the timeout counter; must satisfy 2^TO_W > RESP_TIMEOUT.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
pkt_valid  in  1  sample offered
pkt_ready  out  1  block can accept a sample; high only in IDLE
pos_x, pos_y, pos_z  in  32 each  signed positions
vel_x, vel_y, vel_z  in  32 each  signed velocities
tx_data  out  32  word to serializer
tx_send  out  1  word valid to serializer
tx_ready  in  1  serializer can accept
rx_data  in  32  word from deserializer
rx_avail  in  1  level; high while rx_data valid
cmd_out  out  9  accepted command, 0..256
cmd_valid  out  1  1-cycle pulse, cmd_out updated
range_err  out  1  1-cycle pulse, response outside 0..256
timeout  out  1  1-cycle pulse, no response
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, rst=1): state IDLE; tx_data=0, tx_send=0, cmd_out=0, cmd_valid=0, range_err=0, timeout=0, busy=0, pkt_ready=1. Internal state cleared: word index, gap counter, timeout counter, sample registers, rx_avail_d=0.
- Reset asserted mid-frame or mid-wait: tx_send drops immediately and the frame is abandoned. No partial resume.
- pkt_ready = (state==IDLE), combinational.
- cmd_valid, range_err and timeout are registered; each is high for exactly one cycle per event.
- rx_avail_d is registered every cycle in every state. A response event is rx_avail & ~rx_avail_d.
- States:
  - IDLE:
    - On pkt_valid&pkt_ready, capture all six inputs and set word index=0.
    - Go to SEND with tx_data=START_CODE, tx_send=1 (visible the cycle after the accept edge).
  - SEND:
    - Hold tx_send=1 and keep tx_data stable until an edge with tx_send&tx_ready (accept).
    - On accept: tx_send=0, index+1.
    - If the accepted word was index 6 (vel_z), go to WAIT_RESP with the timeout counter at 0. Otherwise go to GAP with the gap counter at 0.
  - GAP:
    - tx_send=0 and the gap counter increments each cycle.
    - When the counter reaches GAP_CYCLES-1, go to SEND with tx_data=word[index], tx_send=1.
    - With tx_ready held high, consecutive accepts are GAP_CYCLES+1 cycles apart.
  - WAIT_RESP:
    - On a response event: if rx_data is signed 0..256 inclusive, cmd_out<=rx_data[8:0] and cmd_valid pulses. Otherwise range_err pulses and cmd_out is held. Then go to IDLE.
    - Else if the timeout counter == RESP_TIMEOUT-1, timeout pulses and go to IDLE.
    - Else the counter increments.
- Word order: 0 START_CODE, 1 pos_x, 2 pos_y, 3 pos_z, 4 vel_x, 5 vel_y, 6 vel_z. Values are sent as captured, with no sign or abs conversion.
- Response events outside WAIT_RESP are ignored. This covers repeated copies of the command and stale words during SEND/GAP.
- A response event and the timeout terminal count on the same edge: the response wins and timeout does not pulse.
- pkt_valid while busy: ignored, not queued. Input changes after capture have no effect on the frame in flight.
- tx_ready low for any number of cycles stalls SEND indefinitely. The timeout does not run during SEND.

Test Plan:
- Basic frame: tx_ready=1, sample pos=(100,-200,300), vel=(-5,6,7) -> 7 accepts in order AAAAAAAA,100,-200,300,-5,6,7. Accepts spaced exactly 5 cycles apart (GAP_CYCLES=4). busy=1 throughout; pkt_ready=0 until return to IDLE.
- Valid command: after the frame, rx_data=180 and rx_avail raised for 4 cycles -> one cmd_valid pulse, cmd_out=180, back to IDLE. A second rx_avail pulse afterwards causes no pulse.
- Range: response 257 -> range_err pulses and cmd_out holds its prior value. Response 256 -> cmd_valid with cmd_out=256. Response -1 -> range_err.
- Timeout: RESP_TIMEOUT=50, no rx_avail -> timeout pulses exactly 50 cycles after entering WAIT_RESP, then IDLE. A response on the terminal cycle gives cmd_valid and no timeout.
- Backpressure: tx_ready low 20 cycles during word 3 -> tx_send held with tx_data=300 stable; the frame completes correctly once tx_ready returns high.
- Reset mid-frame: rst pulsed during word 4 -> tx_send=0 immediately and all outputs at reset values. A new sample afterwards sends a full frame starting with START_CODE.
